// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: control FSM of a 4-way set-associative cache.
// Looks up the four tag channels, picks a victim on a miss, runs the memory
// handshake (writeback / line fill / write-through) with a wait-cycle
// timeout, and issues the per-way write and LRU-age strobes.
// Build option: define CACHE_CTRL_WRITE_BACK_EN for write-back behaviour;
// when undefined the controller is write-through with write-allocate.
module cache_ctrl_fsm #(
    parameter int MEM_TO = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    output logic        cpu_ack,
    output logic        cpu_hit,
    output logic        cpu_err,
    output logic        busy,
    output logic [7:0]  ch_tag,
    output logic [3:0]  ch_index,
    output logic [3:0]  ch_wr,
    output logic [3:0]  ch_age,
    output logic        ch_mod,
    input  logic [31:0] ch_tag_in,
    input  logic [3:0]  ch_valid,
    input  logic [11:0] ch_lru,
    input  logic [3:0]  ch_mod_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    input  logic        mem_ack
);

`ifdef CACHE_CTRL_WRITE_BACK_EN
    localparam logic WB_EN = 1'b1;
`else
    localparam logic WB_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WBACK  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_WTHRU  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]  state;
    logic        we_r;
    logic [11:0] addr_r;
    logic        hit_r;
    logic        err_r;
    logic [1:0]  way_r;
    logic [7:0]  wb_tag_r;
    logic [7:0]  cnt;

    logic [7:0]  tag_a [4];
    logic [2:0]  lru_a [4];
    logic        hit;
    logic [1:0]  hit_way;
    logic [1:0]  vic_way;
    logic        vic_found;
    logic [2:0]  best_lru;
    logic [2:0]  tgt_lru;
    logic        mem_phase;

    // Unpack the flat channel buses into per-way arrays.
    always_comb begin
        for (int w = 0; w < 4; w++) begin
            tag_a[w] = ch_tag_in[8*w +: 8];
            lru_a[w] = ch_lru[3*w +: 3];
        end
    end

    // Hit detection (lowest matching way wins) and victim choice on a miss:
    // lowest invalid way, else the way at lru=3, else highest lru (ties low).
    always_comb begin
        hit       = 1'b0;
        hit_way   = 2'd0;
        vic_way   = 2'd0;
        vic_found = 1'b0;
        best_lru  = lru_a[0];
        for (int w = 3; w >= 0; w--) begin
            if (ch_valid[w] && tag_a[w] == addr_r[11:4]) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
        for (int w = 3; w >= 0; w--) begin
            if (!ch_valid[w]) begin
                vic_found = 1'b1;
                vic_way   = 2'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 3; w >= 0; w--) begin
                if (lru_a[w] == 3'd3) begin
                    vic_found = 1'b1;
                    vic_way   = 2'(w);
                end
            end
        end
        if (!vic_found) begin
            vic_way = 2'd0;
            for (int w = 1; w < 4; w++) begin
                if (lru_a[w] > best_lru) begin
                    best_lru = lru_a[w];
                    vic_way  = 2'(w);
                end
            end
        end
    end

    // Age every valid way younger than the target; an invalid target counts as age 3.
    always_comb begin
        tgt_lru = ch_valid[way_r] ? lru_a[way_r] : 3'd3;
        ch_age  = 4'b0000;
        if (state == S_UPDATE) begin
            for (int v = 0; v < 4; v++) begin
                if (2'(v) != way_r && ch_valid[v] && lru_a[v] < tgt_lru)
                    ch_age[v] = 1'b1;
            end
        end
    end

    // Main FSM; the wait counter restarts for every memory phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            we_r     <= 1'b0;
            addr_r   <= 12'd0;
            hit_r    <= 1'b0;
            err_r    <= 1'b0;
            way_r    <= 2'd0;
            wb_tag_r <= 8'd0;
            cnt      <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_r   <= cpu_we;
                        addr_r <= cpu_addr;
                        hit_r  <= 1'b0;
                        err_r  <= 1'b0;
                        cnt    <= 8'd0;
                        state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_r <= hit;
                    if (hit) begin
                        way_r <= hit_way;
                        state <= S_UPDATE;
                    end else begin
                        way_r    <= vic_way;
                        wb_tag_r <= tag_a[vic_way];
                        if (WB_EN && ch_valid[vic_way] && ch_mod_in[vic_way])
                            state <= S_WBACK;
                        else
                            state <= S_FILL;
                    end
                end
                S_WBACK, S_FILL, S_WTHRU: begin
                    if (mem_ack) begin
                        cnt <= 8'd0;
                        case (state)
                            S_WBACK: state <= S_FILL;
                            S_FILL:  state <= S_UPDATE;
                            default: state <= S_DONE;
                        endcase
                    end else if (cnt == 8'(MEM_TO - 1)) begin
                        cnt   <= 8'd0;
                        err_r <= 1'b1;
                        hit_r <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_UPDATE: state <= (!WB_EN && we_r) ? S_WTHRU : S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Output decode, all derived from the state and registered request.
    always_comb begin
        mem_phase = (state == S_WBACK) || (state == S_FILL) || (state == S_WTHRU);
        busy      = (state != S_IDLE);
        cpu_ack   = (state == S_DONE);
        cpu_hit   = (state == S_DONE) && hit_r;
        cpu_err   = (state == S_DONE) && err_r;
        ch_tag    = busy ? addr_r[11:4] : 8'd0;
        ch_index  = busy ? addr_r[3:0] : 4'd0;
        ch_wr     = (state == S_UPDATE) ? 4'(4'b0001 << way_r) : 4'b0000;
        ch_mod    = 1'b0;
        if (WB_EN && state == S_UPDATE)
            ch_mod = hit_r ? (ch_mod_in[way_r] | we_r) : we_r;
        mem_req   = mem_phase;
        mem_we    = (state == S_WBACK) || (state == S_WTHRU);
        mem_addr  = 12'd0;
        if (state == S_WBACK)
            mem_addr = {wb_tag_r, addr_r[3:0]};
        else if (mem_phase)
            mem_addr = addr_r;
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm (MEM_TO=4). Channel inputs are set per
// scenario; outputs are sampled 1 time unit after each rising edge.
module tb_cache_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic        cpu_ack, cpu_hit, cpu_err, busy;
    logic [7:0]  ch_tag;
    logic [3:0]  ch_index, ch_wr, ch_age;
    logic        ch_mod;
    logic [31:0] ch_tag_in;
    logic [3:0]  ch_valid;
    logic [11:0] ch_lru;
    logic [3:0]  ch_mod_in;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic        mem_ack;

    int n_pass = 0;
    int n_total = 0;

    cache_ctrl_fsm #(.MEM_TO(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ack(cpu_ack), .cpu_hit(cpu_hit), .cpu_err(cpu_err), .busy(busy),
        .ch_tag(ch_tag), .ch_index(ch_index), .ch_wr(ch_wr), .ch_age(ch_age), .ch_mod(ch_mod),
        .ch_tag_in(ch_tag_in), .ch_valid(ch_valid), .ch_lru(ch_lru), .ch_mod_in(ch_mod_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; on return the FSM is in LOOKUP.
    task automatic issue(input logic we, input logic [11:0] a);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic set_ways(input logic [31:0] tags, input logic [3:0] v,
                            input logic [11:0] lru, input logic [3:0] m);
        ch_tag_in = tags; ch_valid = v; ch_lru = lru; ch_mod_in = m;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h0; mem_ack = 1'b0;
        set_ways(32'h0, 4'b0, 12'h0, 4'b0);
        tick(); tick();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (cpu_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", cpu_ack); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if ({ch_wr, ch_age} !== 8'h00) $display("FAIL reset_strobes: got %h want 00", {ch_wr, ch_age}); else n_pass++;
        n_total++; if ({ch_tag, ch_index, mem_addr} !== 24'h0) $display("FAIL reset_addr: got %h want 000000", {ch_tag, ch_index, mem_addr}); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    // Cold read miss into an empty set: fill from 0x5AF into way 0.
    task automatic test_fill_read();
        set_ways(32'h0, 4'b0000, 12'h0, 4'b0);
        issue(1'b0, 12'h5AF);
        n_total++; if ({busy, ch_tag, ch_index} !== 13'h15AF) $display("FAIL fill_lookup: got %h want 15af", {busy, ch_tag, ch_index}); else n_pass++;
        tick();
        n_total++; if ({mem_req, mem_we, mem_addr} !== 14'h25AF) $display("FAIL fill_mem: got %h want 25af", {mem_req, mem_we, mem_addr}); else n_pass++;
        n_total++; if (ch_wr !== 4'b0000) $display("FAIL fill_no_wr: got %b want 0000", ch_wr); else n_pass++;
        tick();
        n_total++; if ({mem_req, mem_we, mem_addr} !== 14'h25AF) $display("FAIL fill_hold: got %h want 25af", {mem_req, mem_we, mem_addr}); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_total++; if (mem_req !== 1'b0) $display("FAIL fill_req_drop: got %b want 0", mem_req); else n_pass++;
        n_total++; if ({ch_wr, ch_age, ch_mod} !== 9'b0001_0000_0) $display("FAIL fill_update: got %b want 000100000", {ch_wr, ch_age, ch_mod}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, cpu_hit, cpu_err} !== 3'b100) $display("FAIL fill_done: got %b want 100", {cpu_ack, cpu_hit, cpu_err}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, busy} !== 2'b00) $display("FAIL fill_idle: got %b want 00", {cpu_ack, busy}); else n_pass++;
    endtask

    // Repeat read now hits way 0; cpu_req held busy with a new address is ignored.
    task automatic test_hit_read();
        set_ways(32'h0000_005A, 4'b0001, 12'h0, 4'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h5AF;
        tick();                          // accept edge, cycle 1 = LOOKUP
        cpu_addr = 12'h123;
        n_total++; if ({cpu_ack, ch_tag} !== 9'h05A) $display("FAIL hit_lookup: got %h want 05a", {cpu_ack, ch_tag}); else n_pass++;
        tick();                          // cycle 2 = UPDATE
        cpu_req = 1'b0;
        n_total++; if ({cpu_ack, mem_req, ch_wr} !== 6'b00_0001) $display("FAIL hit_update: got %b want 000001", {cpu_ack, mem_req, ch_wr}); else n_pass++;
        tick();                          // cycle 3 = DONE, cpu_ack
        n_total++; if ({cpu_ack, cpu_hit, cpu_err, mem_req} !== 4'b1100) $display("FAIL hit_done: got %b want 1100", {cpu_ack, cpu_hit, cpu_err, mem_req}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, busy} !== 2'b00) $display("FAIL hit_idle: got %b want 00", {cpu_ack, busy}); else n_pass++;
    endtask

    // Full set, way 2 at lru=3 and dirty with tag 0x12; read 0x34F misses.
    task automatic test_victim_dirty();
        set_ways({8'h04, 8'h12, 8'h02, 8'h01}, 4'b1111, {3'd2, 3'd3, 3'd1, 3'd0}, 4'b0100);
        issue(1'b0, 12'h34F);
        tick();
`ifdef CACHE_CTRL_WRITE_BACK_EN
        n_total++; if ({mem_req, mem_we, mem_addr} !== 14'h312F) $display("FAIL vic_wback: got %h want 312f", {mem_req, mem_we, mem_addr}); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
`endif
        n_total++; if ({mem_req, mem_we, mem_addr} !== 14'h234F) $display("FAIL vic_fill: got %h want 234f", {mem_req, mem_we, mem_addr}); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_total++; if ({ch_wr, ch_age, ch_mod} !== 9'b0100_1011_0) $display("FAIL vic_update: got %b want 010010110", {ch_wr, ch_age, ch_mod}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, cpu_hit} !== 2'b10) $display("FAIL vic_done: got %b want 10", {cpu_ack, cpu_hit}); else n_pass++;
        tick();
    endtask

    // Clean read miss: expected target way and age strobes in UPDATE.
    task automatic run_miss(input string name, input logic [11:0] a,
                            input logic [3:0] exp_wr, input logic [3:0] exp_age);
        issue(1'b0, a);
        tick();
        n_total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, a}) $display("FAIL %s_fill: got %h want %h", name, {mem_req, mem_we, mem_addr}, {2'b10, a}); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_total++; if ({ch_wr, ch_age} !== {exp_wr, exp_age}) $display("FAIL %s_update: got %b want %b", name, {ch_wr, ch_age}, {exp_wr, exp_age}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, cpu_hit} !== 2'b10) $display("FAIL %s_done: got %b want 10", name, {cpu_ack, cpu_hit}); else n_pass++;
        tick();
    endtask

    task automatic test_victim_order();
        // Ways 0 and 2 invalid: lowest invalid (way 0) is chosen, L=3 ages ways 1 and 3.
        set_ways({8'h04, 8'h03, 8'h02, 8'h01}, 4'b1010, 12'h0, 4'b0000);
        run_miss("vic_invalid", 12'h991, 4'b0001, 4'b1010);
        // Full set, no lru=3: highest lru 2 on ways 1 and 2, tie to way 1; L=2 ages ways 0,3.
        set_ways({8'h04, 8'h03, 8'h02, 8'h01}, 4'b1111, {3'd0, 3'd2, 3'd2, 3'd1}, 4'b0000);
        run_miss("vic_highest", 12'h992, 4'b0010, 4'b1001);
    endtask

    // Read hit on way 2 (lru=2), others lru 0,1,3: ages ways 0 and 1.
    task automatic test_hit_age();
        set_ways({8'h04, 8'h77, 8'h02, 8'h01}, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0100);
        issue(1'b0, 12'h770);
        tick();
`ifdef CACHE_CTRL_WRITE_BACK_EN
        n_total++; if ({ch_wr, ch_age, ch_mod, mem_req} !== 10'b0100_0011_1_0) $display("FAIL age_update: got %b want 0100001110", {ch_wr, ch_age, ch_mod, mem_req}); else n_pass++;
`else
        n_total++; if ({ch_wr, ch_age, ch_mod, mem_req} !== 10'b0100_0011_0_0) $display("FAIL age_update: got %b want 0100001100", {ch_wr, ch_age, ch_mod, mem_req}); else n_pass++;
`endif
        tick();
        n_total++; if ({cpu_ack, cpu_hit, ch_wr, ch_age} !== 10'b11_0000_0000) $display("FAIL age_done: got %b want 1100000000", {cpu_ack, cpu_hit, ch_wr, ch_age}); else n_pass++;
        tick();
    endtask

    // Write hitting both way 1 and way 2: lowest (way 1, lru=1) wins, ages way 0.
    task automatic test_write_hit();
        set_ways({8'h04, 8'h77, 8'h77, 8'h01}, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000);
        issue(1'b1, 12'h770);
        tick();
`ifdef CACHE_CTRL_WRITE_BACK_EN
        n_total++; if ({ch_wr, ch_age, ch_mod} !== 9'b0010_0001_1) $display("FAIL wr_update: got %b want 001000011", {ch_wr, ch_age, ch_mod}); else n_pass++;
        tick();
`else
        n_total++; if ({ch_wr, ch_age, ch_mod} !== 9'b0010_0001_0) $display("FAIL wr_update: got %b want 001000010", {ch_wr, ch_age, ch_mod}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, mem_req, mem_we, mem_addr} !== 15'h3770) $display("FAIL wr_wthru: got %h want 3770", {cpu_ack, mem_req, mem_we, mem_addr}); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
`endif
        n_total++; if ({cpu_ack, cpu_hit, cpu_err, mem_req} !== 4'b1100) $display("FAIL wr_done: got %b want 1100", {cpu_ack, cpu_hit, cpu_err, mem_req}); else n_pass++;
        tick();
    endtask

    // mem_ack never comes: four wait cycles in FILL, then DONE with cpu_err.
    task automatic test_timeout();
        set_ways(32'h0, 4'b0000, 12'h0, 4'b0);
        issue(1'b0, 12'hABC);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_total++; if ({mem_req, cpu_ack, ch_wr} !== 6'b10_0000) $display("FAIL to_wait%0d: got %b want 100000", i, {mem_req, cpu_ack, ch_wr}); else n_pass++;
            tick();
        end
        n_total++; if ({cpu_ack, cpu_err, cpu_hit, mem_req, ch_wr} !== 8'b1100_0000) $display("FAIL to_done: got %b want 11000000", {cpu_ack, cpu_err, cpu_hit, mem_req, ch_wr}); else n_pass++;
        tick();
        n_total++; if ({cpu_ack, cpu_err, busy} !== 3'b000) $display("FAIL to_idle: got %b want 000", {cpu_ack, cpu_err, busy}); else n_pass++;
    endtask

    // Reset while the fill is outstanding abandons it with no cpu_ack.
    task automatic test_reset_fill();
        set_ways(32'h0, 4'b0000, 12'h0, 4'b0);
        issue(1'b0, 12'h5AF);
        tick();
        n_total++; if (mem_req !== 1'b1) $display("FAIL rf_in_fill: got %b want 1", mem_req); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if ({mem_req, busy, cpu_ack} !== 3'b000) $display("FAIL rf_reset: got %b want 000", {mem_req, busy, cpu_ack}); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if ({mem_req, busy, cpu_ack} !== 3'b000) $display("FAIL rf_after: got %b want 000", {mem_req, busy, cpu_ack}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_hit_read();
        test_victim_dirty();
        test_victim_order();
        test_hit_age();
        test_write_hit();
        test_timeout();
        test_reset_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_fsm.md
CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

Interface
REQ-001 SHALL have parameter: MEM_TO, 64, max cycles waiting for mem_ack before abort (range 2..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe, sampled in IDLE.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  12  line address: [11:4] tag, [3:0] index.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_hit  out  1  valid with cpu_ack: 1=hit.
- cpu_err  out  1  one-cycle pulse with cpu_ack on memory timeout.
- busy  out  1  high whenever state != IDLE.
- ch_tag  out  8  tag to all four channels.
- ch_index  out  4  set index to all four channels.
- ch_wr  out  4  per-way write strobe.
- ch_age  out  4  per-way LRU age strobe.
- ch_mod  out  1  mod value written with ch_wr.
- ch_tag_in  in  32  way w stored tag at [8w+7:8w].
- ch_valid  in  4  per-way valid.
- ch_lru  in  12  way w LRU at [3w+2:3w].
- ch_mod_in  in  4  per-way dirty bit.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  1=writeback/write, 0=line fill.
- mem_addr  out  12  memory line address.
- mem_ack  in  1  memory completion.

Function
REQ-003 SHALL implement states IDLE, LOOKUP, WBACK, FILL, UPDATE, WTHRU, DONE.
REQ-004 SHALL, in IDLE with cpu_req=1, register cpu_we/cpu_addr and go to LOOKUP; cpu_req in any other state SHALL be ignored.
REQ-005 SHALL drive ch_tag/ch_index from registered address from LOOKUP through DONE; channel outputs are treated as combinational in the same cycle.
REQ-006 SHALL declare hit when exactly the way with ch_valid=1 and matching tag exists; multiple matches SHALL select lowest way.
REQ-007 SHALL, on hit, go LOOKUP->UPDATE; hit read latency from accept edge to cpu_ack = 3 cycles.
REQ-008 SHALL, on miss, select victim: lowest-numbered invalid way; else way with lru=3; else highest lru, ties to lowest way.
REQ-009 SHALL, on miss, go to WBACK if victim valid and dirty (macro enabled), else FILL.
REQ-010 SHALL in WBACK assert mem_req=1, mem_we=1, mem_addr={victim tag, index}; in FILL mem_req=1, mem_we=0, mem_addr=registered address.
REQ-011 SHALL hold mem_req/mem_we/mem_addr stable until mem_ack sampled high, then deassert mem_req next cycle; WBACK->FILL, FILL->UPDATE.
REQ-012 SHALL count wait cycles per memory phase; count reaching MEM_TO SHALL drop mem_req, go DONE with cpu_err=1, cpu_hit=0, no channel write.
REQ-013 SHALL in UPDATE pulse, for one cycle, ch_wr[w]=1 for target way w and ch_age[v]=1 for every valid v!=w with lru_v < L, L = lru_w (L=3 if w invalid).
REQ-014 SHALL drive ch_mod in UPDATE as ch_mod_in[w]|cpu_we on hit, cpu_we on fill (macro enabled).
REQ-015 SHALL go UPDATE->DONE, except write-through writes go UPDATE->WTHRU.
REQ-016 SHALL pulse cpu_ack one cycle in DONE, then IDLE; cpu_hit reflects LOOKUP result.
REQ-017 SHALL never assert ch_wr, ch_age outside UPDATE.

Reset
REQ-018 SHALL on rst=1 enter IDLE, clear timeout counter and registers; all outputs 0 next edge.
REQ-019 SHALL abandon any in-flight operation at rst without cpu_ack; mem_req drops next edge.

Configuration
REQ-020 SHALL use macro CACHE_CTRL_WRITE_BACK_EN: defined = write-back, dirty victims written back in WBACK, WTHRU unused; undefined = write-through, write-allocate, ch_mod always 0, WBACK unreachable, every write passes WTHRU issuing mem_we=1 at registered address with REQ-011/REQ-012 handshake.

Verification
REQ-021 Reset, all ways invalid, read 0x5AF -> FILL mem_addr=0x5AF, ch_wr=0001, cpu_hit=0.
REQ-022 Repeat read 0x5AF -> cpu_ack 3 cycles after accept, cpu_hit=1, no mem_req.
REQ-023 Set full, victim lru=3 dirty (tag 0x12, index 0xF), read 0x34F, macro on -> WBACK mem_addr=0x12F, then FILL 0x34F.
REQ-024 Hit way 2 with lru=2, others lru 0,1,3 -> ch_wr=0100, ch_age=0011.
REQ-025 mem_ack never asserted, MEM_TO=4 -> cpu_ack with cpu_err=1 after 4 wait cycles, ch_wr stays 0.
REQ-026 rst during FILL -> mem_req 0 next edge, busy 0, no cpu_ack.
